// File: rtl/sd_spi_engine.sv
// sd_spi_engine: SPI master for SD-card access from the 8086 bus.
// It has a programmable SCLK divider, NUM_CS card selects, and hardware block
// transfers between the card and a private sector buffer RAM.
//
// Ports
//   clk, reset             system clock; asynchronous active-high reset
//   cs_n, rd_n, wr_n       active-low bus select and strobes
//   addr[1:0]              register select: 0 CTRL/STATUS, 1 DIV, 2 DATA, 3 BLOCK
//   din[7:0], dout[7:0]    bus write data; registered bus read data
//   card_det               card-present input (asynchronous)
//   irq                    done & irq_en
//   ram_addr, ram_wdata, ram_rdata, ram_we
//                          sector buffer port (ram_rdata has one-cycle latency)
//   sd_cs_n[NUM_CS-1:0]    card selects; sclk, mosi, miso: SPI mode 0, MSB first
module sd_spi_engine #(
  parameter int          NUM_CS  = 2,
  parameter int          BUF_AW  = 9,
  parameter logic [7:0]  DIV_RST = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [1:0]        addr,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  input  logic              card_det,
  output logic              irq,
  output logic [BUF_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              ram_we,
  output logic [NUM_CS-1:0] sd_cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SHIFT, STORE, NEXT} state_t;

  state_t              state, state_nx;
  logic                wr_q, rd_q, stat_rd;
  logic [7:0]          div, cnt, tx, rx;
  logic [3:0]          half;
  logic [BUF_AW-1:0]   idx;
  logic                blk, mode, irq_en, done, sclk_q;
  logic [NUM_CS-1:0]   cs_sel;
  logic [1:0]          cd_sync;

  logic wr_act, wr_fire, rd_act, rd_rise, idle;
  logic start_byte, start_blk, half_end, shift_end, last;

  // A write is accepted only on the first clock of a strobe.
  assign wr_act     = ~cs_n & ~wr_n;
  assign wr_fire    = wr_act & ~wr_q;
  assign rd_act     = ~cs_n & ~rd_n;
  assign rd_rise    = rd_n & ~rd_q;
  assign idle       = (state == IDLE);
  assign start_byte = wr_fire && idle && (addr == 2'd2);
  assign start_blk  = wr_fire && idle && (addr == 2'd3);
  assign half_end   = (cnt == div);
  assign shift_end  = (state == SHIFT) && half_end && (half == 4'hF);
  assign last       = &idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_byte)     state_nx = SHIFT;
        else if (start_blk) state_nx = din[0] ? FETCH : SHIFT;
      end
      FETCH:   state_nx = LATCH;
      LATCH:   state_nx = SHIFT;
      SHIFT: begin
        if (shift_end) state_nx = !blk ? IDLE : (mode ? NEXT : STORE);
      end
      STORE:   state_nx = NEXT;
      NEXT: begin
        if (last) state_nx = IDLE;
        else      state_nx = mode ? FETCH : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b1;
      stat_rd <= 1'b0;
      cd_sync <= '0;
      div     <= DIV_RST;
      cnt     <= '0;
      half    <= '0;
      tx      <= '1;
      rx      <= '0;
      idx     <= '0;
      blk     <= 1'b0;
      mode    <= 1'b0;
      irq_en  <= 1'b0;
      cs_sel  <= '0;
      done    <= 1'b0;
      sclk_q  <= 1'b0;
      dout    <= '0;
    end else begin
      wr_q    <= wr_act;
      rd_q    <= rd_n;
      cd_sync <= {cd_sync[0], card_det};

      // Register writes are honoured only while idle.
      if (wr_fire && idle) begin
        case (addr)
          2'd0: begin
            cs_sel <= din[NUM_CS-1:0];
            irq_en <= din[4];
          end
          2'd1: div <= din;
          2'd2: begin
            tx  <= din;
            blk <= 1'b0;
          end
          default: begin
            mode <= din[0];
            blk  <= 1'b1;
            idx  <= '0;
            tx   <= 8'hFF;
          end
        endcase
      end

      // Bit timing restarts from zero on every entry to SHIFT.
      if (state != SHIFT) begin
        cnt  <= '0;
        half <= '0;
      end

      case (state)
        LATCH: tx <= ram_rdata;
        SHIFT: begin
          if (half_end) begin
            cnt    <= '0;
            half   <= half + 4'd1;
            sclk_q <= ~sclk_q;
            // rising edge samples miso; falling edge presents the next bit
            if (!sclk_q) rx <= {rx[6:0], miso};
            else         tx <= {tx[6:0], 1'b1};
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        NEXT: begin
          if (last) idx <= '0;
          else      idx <= idx + BUF_AW'(1);
          if (!mode) tx <= 8'hFF;
        end
        default: ;
      endcase

      // done clears on the rd_n rise that ends a STATUS read; a completion
      // in the same clock takes priority.
      if (rd_act && addr == 2'd0) stat_rd <= 1'b1;
      else if (rd_rise)           stat_rd <= 1'b0;
      if (rd_rise && stat_rd) done <= 1'b0;
      if ((shift_end && !blk) || (state == NEXT && last)) done <= 1'b1;

      if (rd_act) begin
        case (addr)
          2'd0:    dout <= {5'b0, cd_sync[1], done, ~idle};
          2'd1:    dout <= div;
          2'd2:    dout <= rx;
          default: dout <= {7'b0, mode};
        endcase
      end
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = tx[7];
  assign sd_cs_n   = ~cs_sel;
  assign irq       = done & irq_en;
  assign ram_addr  = idx;
  assign ram_wdata = rx;
  assign ram_we    = (state == STORE);

endmodule

// File: doc/sd_spi_engine.md
# sd_spi_engine

Parametrised SPI master engine for SD-card access from the 8086 bus, the next generation of the SD controller. Adds a programmable SCLK divider, multiple card selects, and hardware block transfers between the card and the sector buffer RAM, so the CPU no longer shifts each byte by hand. Sits between the CPU bus decode and the SD socket(s), with a private port onto the sector buffer.

## Interface
- NUM_CS, 2: number of card-select outputs (1..4).
- BUF_AW, 9: sector buffer address width; a block is 2^BUF_AW bytes.
- DIV_RST, 8'hFF: reset value of the divider register (slow init clock).

- clk  in  1  system clock (20 MHz); all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs_n, rd_n, wr_n  in  1 each  active-low bus select and strobes.
- addr  in  2  register select.
- din  in  8  bus write data; dout  out  8  bus read data.
- card_det  in  1  card-present, synchronised internally with two flops.
- irq  out  1  done & irq_en.
- ram_addr  out  BUF_AW; ram_wdata  out  8; ram_rdata  in  8 (one-cycle read latency); ram_we  out  1 (active-high).
- sd_cs_n  out  NUM_CS; sclk  out  1; mosi  out  1; miso  in  1.

## Operation
- Bus write fires once, on the first clk with cs_n=0 and wr_n=0; a strobe held for several clocks does not retrigger. A new write requires wr_n high for at least one clk first.
- addr 0 write, CTRL: [3:0] cs_sel, one-hot, bits at or above NUM_CS ignored; [4] irq_en. sd_cs_n = ~cs_sel. Ignored while busy.
- addr 0 read, STATUS: [0] busy, [1] done, [2] card_det, rest 0.
  - done is sticky.
  - done clears on the rising edge of rd_n after a status read.
- addr 1, DIV: SCLK half-period = DIV+1 clk. Write ignored while busy. Read returns DIV.
- addr 2, DATA:
  - Write starts a single-byte transfer of din.
  - Read returns the last received byte.
- addr 3, BLOCK: write starts a block transfer. Read returns {7'b0, last mode}.
  - din[0]=0: block read. Send 8'hFF 2^BUF_AW times and store each received byte at ram[i].
  - din[0]=1: block write. Send ram[0..2^BUF_AW-1]; received bytes are discarded.
- Any start write (addr 2 or 3) while busy is ignored entirely.
- SPI mode 0, MSB first:
  - mosi is valid before the first rising sclk edge and changes only after falling edges.
  - miso is sampled at the rising sclk edge.
- FSM states: IDLE, FETCH, LATCH, SHIFT, STORE, NEXT.
  - IDLE: start single byte -> SHIFT. Start block read -> SHIFT with tx=FF, i=0. Start block write -> FETCH.
  - FETCH drives ram_addr=i. LATCH captures ram_rdata into tx on the next clk, then -> SHIFT.
  - SHIFT runs 16 half-periods (8 bits), then -> STORE (block read), NEXT (block write), or IDLE (single byte).
  - STORE holds ram_we=1 for exactly one clk, with ram_addr=i and ram_wdata=rx, then -> NEXT.
  - NEXT: if i = 2^BUF_AW-1 -> IDLE and set done. Otherwise increment i (wraps to 0 only at the end) and -> FETCH or SHIFT.
- Single-byte completion also sets done.

## Timing
- Reset values:
  - sclk=0, mosi=1, sd_cs_n=all 1, irq=0, ram_we=0, ram_addr=0, ram_wdata=0, dout=0.
  - DIV=DIV_RST, cs_sel=0, irq_en=0, done=0, busy=0, state IDLE.
- Reset mid-transfer aborts immediately: sclk low, sd_cs_n high, no further ram_we.
- busy goes to 1 on the clk after the accepted write strobe.
- Single byte: busy lasts 16*(DIV+1) clk. done and irq assert on the clk busy falls.
- Block read: 2^BUF_AW*(16*(DIV+1)+2) clk. Block write: 2^BUF_AW*(16*(DIV+1)+3) clk.
- There are no sclk edges outside SHIFT. sclk idles low between bytes.
- dout is registered, valid on the clk after cs_n=0 and rd_n=0 with stable addr.

## Test plan
- Single byte, DIV=0, miso looped to mosi: write 8'h40 to addr 2 -> 8 sclk pulses of period 2 clk, mosi sequence 0,1,0,0,0,0,0,0, busy high for 16 clk, then addr 2 reads 8'h40 and done=1.
- Write 8'hFF to addr 2 with a 2-clk wr_n strobe -> exactly one transfer of 8 pulses. DIV=8'hFF -> sclk half-period of 256 clk.
- Block read, BUF_AW=9, DIV=0, miso driven from a 512-byte pattern p[i]=i[7:0]^8'hA5 -> 512 ram_we pulses, ram[i]=p[i], mosi constantly 1, irq rises after the final store when irq_en=1.
- Block write with ram[i]=i[7:0] -> mosi carries bytes 00..FF,00..FF in order, ram_we never asserts, the last ram_addr is 9'h1FF.
- Write-while-busy: write 8'h12 to addr 2 and a CTRL/DIV write during a transfer -> all ignored, tx byte and DIV unchanged. A status read clears done on rd_n rise.
- Assert reset at bit 3 of a block read -> next clk sclk=0, sd_cs_n=all 1, busy=0. After release, a new single-byte transfer completes normally.
